// File: rtl/aurora_axi_pkg.sv
// Shared AXI4-Lite definitions for the pipeline memory bridges.
// State codes are plain localparams so older netlists and waveform scripts keep their encodings.
package aurora_axi_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef logic [2:0] axi_bram_state_t;

   localparam axi_bram_state_t ST_IDLE      = 3'd0;
   localparam axi_bram_state_t ST_W_COLLECT = 3'd1;
   localparam axi_bram_state_t ST_W_EXEC    = 3'd2;
   localparam axi_bram_state_t ST_W_RESP    = 3'd3;
   localparam axi_bram_state_t ST_R_EXEC    = 3'd4;
   localparam axi_bram_state_t ST_R_WAIT    = 3'd5;
   localparam axi_bram_state_t ST_R_RESP    = 3'd6;

endpackage

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite responder driving one BRAM port, one transaction at a time.
// Reads and writes alternate when both are pending; all responses are OKAY.
module axi_lite_bram_slave
   import aurora_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  bram_en,
   output logic [3:0]            bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [31:0]           bram_wrdata,
   input  logic [31:0]           bram_rddata
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY);

   axi_bram_state_t state;

   logic                  last_rd;
   logic                  served_any;
   logic                  aw_got;
   logic                  w_got;
   logic [ADDR_WIDTH-1:2] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic [CNT_W-1:0]      lat_cnt;

   logic                  grant_w;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  wr_launch;
   logic [ADDR_WIDTH-1:2] wr_addr_eff;
   logic [31:0]           wr_data_eff;
   logic [3:0]            wr_strb_eff;

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign s_axi_bresp  = AXI_OKAY;
   assign s_axi_rresp  = AXI_OKAY;
   assign s_axi_bvalid = (state == ST_W_RESP);
   assign s_axi_rvalid = (state == ST_R_RESP);

   // Write wins a contest unless the previous winner was a write; the very first contest after reset goes to the write.
   always_comb begin
      grant_w       = (s_axi_awvalid || s_axi_wvalid) && (!s_axi_arvalid || last_rd || !served_any);
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_arready = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               s_axi_awready = grant_w;
               s_axi_wready  = grant_w;
               s_axi_arready = s_axi_arvalid && !grant_w;
            end
            ST_W_COLLECT: begin
               s_axi_awready = !aw_got;
               s_axi_wready  = !w_got;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      aw_hs       = s_axi_awvalid && s_axi_awready;
      w_hs        = s_axi_wvalid && s_axi_wready;
      ar_hs       = s_axi_arvalid && s_axi_arready;
      wr_addr_eff = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_addr_q;
      wr_data_eff = w_hs ? s_axi_wdata : w_data_q;
      wr_strb_eff = w_hs ? s_axi_wstrb : w_strb_q;
      wr_launch   = (aw_got || aw_hs) && (w_got || w_hs);
   end

   // BRAM strobes are pulsed for the single exec cycle; address and write data simply hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_rd     <= 1'b0;
         served_any  <= 1'b0;
         aw_got      <= 1'b0;
         w_got       <= 1'b0;
         aw_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         lat_cnt     <= '0;
         s_axi_rdata <= '0;
         bram_en     <= 1'b0;
         bram_we     <= 4'h0;
         bram_addr   <= '0;
         bram_wrdata <= '0;
      end else begin
         bram_en <= 1'b0;
         bram_we <= 4'h0;
         if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
         end
         if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         case (state)
            ST_IDLE, ST_W_COLLECT: begin
               if (aw_hs || w_hs || state == ST_W_COLLECT) begin
                  if (wr_launch) begin
                     state       <= ST_W_EXEC;
                     bram_en     <= 1'b1;
                     bram_we     <= wr_strb_eff;
                     bram_addr   <= {wr_addr_eff, 2'b00};
                     bram_wrdata <= wr_data_eff;
                  end else begin
                     state <= ST_W_COLLECT;
                  end
               end else if (ar_hs) begin
                  state     <= ST_R_EXEC;
                  bram_en   <= 1'b1;
                  bram_addr <= {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
               end
            end
            ST_W_EXEC: begin
               state      <= ST_W_RESP;
               aw_got     <= 1'b0;
               w_got      <= 1'b0;
               last_rd    <= 1'b0;
               served_any <= 1'b1;
            end
            ST_W_RESP: begin
               if (s_axi_bready) state <= ST_IDLE;
            end
            ST_R_EXEC: begin
               state   <= ST_R_WAIT;
               lat_cnt <= CNT_W'(1);
            end
            ST_R_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  state       <= ST_R_RESP;
                  s_axi_rdata <= bram_rddata;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            ST_R_RESP: begin
               if (s_axi_rready) begin
                  state      <= ST_IDLE;
                  last_rd    <= 1'b1;
                  served_any <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Self-checking bench for axi_lite_bram_slave with a one-cycle BRAM model and a read-data scoreboard.
module tb_axi_lite_bram_slave;

   localparam int AW  = 16;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] awaddr;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic          bram_en;
   logic [3:0]    bram_we;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_wrdata;
   logic [31:0]   bram_rddata;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [31:0] exp_q[$];
   byte         exp_grant[$];
   logic [31:0] mem    [0:255] = '{default: 32'h0};
   logic [31:0] shadow [0:255] = '{default: 32'h0};

   always #5 clk = ~clk;

   axi_lite_bram_slave #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
   );

   // Read-before-write BRAM with one cycle of read latency.
   always @(posedge clk) begin
      if (bram_en) begin
         bram_rddata <= mem[bram_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr[9:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
   end

   task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] exp);
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic shadow_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int aw_wait);
      bit aw_done = 0;
      bit w_done  = 0;
      bit b_done  = 0;
      aw_wait = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
         @(negedge clk);
         if (awvalid && awready) aw_done = 1;
         else if (!aw_done) aw_wait++;
         if (wvalid && wready) w_done = 1;
         @(posedge clk); #1;
         if (aw_done) awvalid = 1'b0;
         if (w_done)  wvalid  = 1'b0;
      end
      if (!(aw_done && w_done)) begin
         n_compared++; n_mismatched++;
         fail_line("write_addr_data_timeout", {30'b0, aw_done, w_done}, 32'h3);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      for (int n = 0; n < 50 && !b_done; n++) begin
         @(negedge clk);
         if (bvalid && bready) b_done = 1;
         @(posedge clk); #1;
      end
      if (!b_done) begin
         n_compared++; n_mismatched++;
         fail_line("write_resp_timeout", 32'h0, 32'h1);
         return;
      end
      shadow_write(a, d, s);
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d);
      bit ar_done = 0;
      bit r_done  = 0;
      d = 'x;
      araddr = a; arvalid = 1'b1;
      for (int n = 0; n < 50 && !ar_done; n++) begin
         @(negedge clk);
         if (arready) ar_done = 1;
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      if (!ar_done) begin
         n_compared++; n_mismatched++;
         fail_line("read_addr_timeout", 32'h0, 32'h1);
         return;
      end
      for (int n = 0; n < 50 && !r_done; n++) begin
         @(negedge clk);
         if (rvalid && rready) begin
            r_done = 1;
            d = rdata;
         end
         @(posedge clk); #1;
      end
      if (!r_done) begin
         n_compared++; n_mismatched++;
         fail_line("read_data_timeout", 32'h0, 32'h1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_compared++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         n_mismatched++;
         fail_line("reset_ready_valid", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h0);
      end
      n_compared++;
      if ({bram_en, bram_we} !== 5'b0) begin
         n_mismatched++;
         fail_line("reset_bram_en_we", {27'b0, bram_en, bram_we}, 32'h0);
      end
      n_compared++;
      if (rdata !== 32'h0 || bram_addr !== '0 || bram_wrdata !== 32'h0) begin
         n_mismatched++;
         fail_line("reset_data_regs", rdata | bram_wrdata | {16'h0, bram_addr}, 32'h0);
      end
      n_compared++;
      if (bresp !== 2'b00 || rresp !== 2'b00) begin
         n_mismatched++;
         fail_line("resp_codes_okay", {28'b0, bresp, rresp}, 32'h0);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      logic [31:0] exp;
      awaddr = 16'h0010; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      n_compared++;
      if ({awready, wready} !== 2'b11) begin
         n_mismatched++;
         fail_line("t1_aw_w_ready", {30'b0, awready, wready}, 32'h3);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      shadow_write(16'h0010, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      n_compared++;
      if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 16'h0010 || bram_wrdata !== 32'hDEADBEEF) begin
         n_mismatched++;
         fail_line("t1_bram_write_cycle", {bram_we, 11'b0, bram_en, bram_addr}, 32'hF0010010);
      end
      @(negedge clk);
      n_compared++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         n_mismatched++;
         fail_line("t1_bvalid_at_t2", {29'b0, bvalid, bresp}, 32'h4);
      end
      @(posedge clk); #1;
      exp_q.push_back(shadow[8'h04]);
      araddr = 16'h0010; arvalid = 1'b1;
      @(negedge clk);
      n_compared++;
      if (arready !== 1'b1) begin
         n_mismatched++;
         fail_line("t1_arready", {31'b0, arready}, 32'h1);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      n_compared++;
      if (bram_en !== 1'b1 || bram_we !== 4'h0) begin
         n_mismatched++;
         fail_line("t1_read_exec", {27'b0, bram_en, bram_we}, 32'h10);
      end
      @(negedge clk);
      n_compared++;
      if (rvalid !== 1'b0) begin
         n_mismatched++;
         fail_line("t1_rvalid_early", {31'b0, rvalid}, 32'h0);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      n_compared++;
      if (rvalid !== 1'b1 || rdata !== exp) begin
         n_mismatched++;
         fail_line("t1_rdata_at_t3", rdata, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_partial_strobe();
      int          w8;
      logic [31:0] got;
      logic [31:0] exp;
      do_write(16'h0020, 32'h11223344, 4'hF, w8);
      wdata = 32'h0000AAAA; wstrb = 4'b0011; wvalid = 1'b1;
      @(negedge clk);
      n_compared++;
      if (wready !== 1'b1) begin
         n_mismatched++;
         fail_line("t2_w_first_ready", {31'b0, wready}, 32'h1);
      end
      @(posedge clk); #1;
      wvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_compared++;
         if (bram_en !== 1'b0 || awready !== 1'b1 || wready !== 1'b0 || arready !== 1'b0) begin
            n_mismatched++;
            fail_line("t2_collect_wait", {28'b0, bram_en, awready, wready, arready}, 32'h4);
         end
         @(posedge clk); #1;
      end
      awaddr = 16'h0020; awvalid = 1'b1;
      @(negedge clk);
      n_compared++;
      if (awready !== 1'b1 || wready !== 1'b0) begin
         n_mismatched++;
         fail_line("t2_aw_late_ready", {30'b0, awready, wready}, 32'h2);
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      n_compared++;
      if (bram_en !== 1'b1 || bram_we !== 4'b0011 || bram_wrdata !== 32'h0000AAAA) begin
         n_mismatched++;
         fail_line("t2_bram_partial", {bram_we, 27'b0, bram_en}, 32'h30000001);
      end
      @(negedge clk);
      n_compared++;
      if (bvalid !== 1'b1) begin
         n_mismatched++;
         fail_line("t2_bvalid", {31'b0, bvalid}, 32'h1);
      end
      @(posedge clk); #1;
      exp_q.push_back(32'h1122AAAA);
      do_read(16'h0020, got);
      exp = exp_q.pop_front();
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         fail_line("t2_readback", got, exp);
      end
      shadow_write(16'h0020, 32'h0000AAAA, 4'b0011);
   endtask

   task automatic test_zero_strobe();
      int          w8;
      logic [31:0] got;
      logic [31:0] exp;
      bit          saw_we = 0;
      exp_q.push_back(shadow[8'h08]);
      fork
         do_write(16'h0020, 32'hFFFFFFFF, 4'h0, w8);
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bram_en && bram_we !== 4'h0) saw_we = 1;
         end
      join
      n_compared++;
      if (saw_we !== 1'b0) begin
         n_mismatched++;
         fail_line("zero_strobe_we", {31'b0, saw_we}, 32'h0);
      end
      do_read(16'h0022, got);
      exp = exp_q.pop_front();
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         fail_line("zero_strobe_readback", got, exp);
      end
   endtask

   task automatic test_backpressure();
      bit          seen = 0;
      logic [31:0] got;
      logic [31:0] exp;
      bready = 1'b0;
      awaddr = 16'h0060; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      shadow_write(16'h0060, 32'h0BADF00D, 4'hF);
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (bvalid) seen = 1;
         @(posedge clk); #1;
      end
      n_compared++;
      if (!seen) begin
         n_mismatched++;
         fail_line("bp_bvalid_timeout", 32'h0, 32'h1);
      end
      exp_q.push_back(shadow[8'h18]);
      araddr = 16'h0060; arvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_compared++;
         if (bvalid !== 1'b1 || awready !== 1'b0 || arready !== 1'b0) begin
            n_mismatched++;
            fail_line("bp_hold", {29'b0, bvalid, awready, arready}, 32'h4);
         end
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(negedge clk);
      n_compared++;
      if (bvalid !== 1'b1) begin
         n_mismatched++;
         fail_line("bp_release_bvalid", {31'b0, bvalid}, 32'h1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_compared++;
      if (arready !== 1'b1 || bvalid !== 1'b0) begin
         n_mismatched++;
         fail_line("bp_next_accept", {30'b0, arready, bvalid}, 32'h2);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      seen = 0;
      got = 'x;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (rvalid) begin
            seen = 1;
            got = rdata;
         end
         @(posedge clk); #1;
      end
      exp = exp_q.pop_front();
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         fail_line("bp_readback", got, exp);
      end
   endtask

   task automatic test_back_to_back();
      int          w8;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] got;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         s = 4'($urandom_range(1, 15));
         do_write(16'h0080 + 16'(4 * i), d, s, w8);
         n_compared++;
         if (w8 != 0) begin
            n_mismatched++;
            fail_line("b2b_aw_wait", 32'(w8), 32'h0);
         end
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(shadow[8'h20 + 8'(i)]);
      for (int i = 0; i < 4; i++) begin
         do_read(16'h0080 + 16'(4 * i), got);
         exp = exp_q.pop_front();
         n_compared++;
         if (got !== exp) begin
            n_mismatched++;
            fail_line("b2b_readback", got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      bit          stale = 0;
      logic [31:0] got;
      logic [31:0] exp;
      araddr = 16'h0010; arvalid = 1'b1;
      @(negedge clk);
      n_compared++;
      if (arready !== 1'b1) begin
         n_mismatched++;
         fail_line("rst_rd_arready", {31'b0, arready}, 32'h1);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if (rvalid !== 1'b0 || bram_en !== 1'b0) begin
         n_mismatched++;
         fail_line("rst_rd_cleared", {30'b0, rvalid, bram_en}, 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rvalid) stale = 1;
      end
      n_compared++;
      if (stale !== 1'b0) begin
         n_mismatched++;
         fail_line("rst_rd_no_stale_rvalid", {31'b0, stale}, 32'h0);
      end
      @(posedge clk); #1;
      exp_q.push_back(shadow[8'h04]);
      do_read(16'h0010, got);
      exp = exp_q.pop_front();
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         fail_line("rst_rd_recover", got, exp);
      end
   endtask

   task automatic test_arbitration();
      byte g;
      byte e;
      int  grants = 0;
      reset = 1'b1;
      awaddr = 16'h0044; wdata = 32'hC0FFEE00; wstrb = 4'hF;
      araddr = 16'h0044;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      exp_grant.push_back("W"); exp_grant.push_back("R");
      exp_grant.push_back("W"); exp_grant.push_back("R");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int n = 0; n < 100 && grants < 4; n++) begin
         @(negedge clk);
         g = 0;
         if (awvalid && awready && wvalid && wready) g = "W";
         else if (arvalid && arready) g = "R";
         if (g != 0) begin
            e = exp_grant.pop_front();
            grants++;
            n_compared++;
            if (g !== e) begin
               n_mismatched++;
               fail_line("arb_order", 32'(g), 32'(e));
            end
         end
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      shadow_write(16'h0044, 32'hC0FFEE00, 4'hF);
      n_compared++;
      if (grants != 4) begin
         n_mismatched++;
         fail_line("arb_grant_count", 32'(grants), 32'h4);
      end
      repeat (10) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
      wdata = '0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_partial_strobe();
      test_zero_strobe();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_read();
      test_arbitration();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
